// File: rtl/gpio_irq_ctrl_if.sv
// Bundle of GPIO edge inputs, register port and interrupt handshake between
// the GPIO interrupt controller (slave) and the bus/core side (master).
interface gpio_irq_ctrl_if #(
  parameter int N = 8
);
  localparam int VW = $clog2(N);

  logic [N-1:0]  rise;
  logic [N-1:0]  fall;
  logic          reg_we;
  logic          reg_re;
  logic [1:0]    reg_addr;
  logic [N-1:0]  reg_wdata;
  logic [N-1:0]  reg_rdata;
  logic          irq;
  logic [VW-1:0] irq_vec;
  logic          irq_ack;

  modport master (
    output rise, fall, reg_we, reg_re, reg_addr, reg_wdata, irq_ack,
    input  reg_rdata, irq, irq_vec
  );

  modport slave (
    input  rise, fall, reg_we, reg_re, reg_addr, reg_wdata, irq_ack,
    output reg_rdata, irq, irq_vec
  );
endinterface

// File: rtl/gpio_irq_ctrl.sv
// Edge-event GPIO interrupt controller: qualifies edge pulses, latches them as
// pending and raises one masked, fixed-priority request with a held vector.
module gpio_irq_ctrl #(
  parameter  int N  = 8,
  localparam int VW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  gpio_irq_ctrl_if.slave bus
);

  localparam logic [1:0] A_EN_RISE = 2'd0;
  localparam logic [1:0] A_EN_FALL = 2'd1;
  localparam logic [1:0] A_PENDING = 2'd2;
  localparam logic [1:0] A_MASK    = 2'd3;

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_e;

  state_e        state_q;
  logic [VW-1:0] vec_q;

  logic [N-1:0] en_rise_q, en_rise_d;
  logic [N-1:0] en_fall_q, en_fall_d;
  logic [N-1:0] pend_q,    pend_d;
  logic [N-1:0] mask_q,    mask_d;
  logic [N-1:0] rdata_q,   rdata_d;

  logic [N-1:0]  ev;
  logic [N-1:0]  clr;
  logic [N-1:0]  act_q;
  logic [N-1:0]  act_d;
  logic [VW-1:0] sel;
  logic          ack_fire;

  always_comb begin
    ev       = (bus.rise & en_rise_q) | (bus.fall & en_fall_q);
    ack_fire = (state_q == REQ) && bus.irq_ack;

    clr = '0;
    if (bus.reg_we && bus.reg_addr == A_PENDING) clr = bus.reg_wdata;
    if (ack_fire) clr = clr | (N'(1) << vec_q);

    // A new event in the same cycle as a clear keeps the bit set
    pend_d    = (pend_q & ~clr) | ev;
    en_rise_d = (bus.reg_we && bus.reg_addr == A_EN_RISE) ? bus.reg_wdata : en_rise_q;
    en_fall_d = (bus.reg_we && bus.reg_addr == A_EN_FALL) ? bus.reg_wdata : en_fall_q;
    mask_d    = (bus.reg_we && bus.reg_addr == A_MASK)    ? bus.reg_wdata : mask_q;

    act_q = pend_q & mask_q;
    act_d = pend_d & mask_d;

    sel = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (act_q[i]) sel = VW'(i);
    end

    rdata_d = rdata_q;
    if (bus.reg_re) begin
      case (bus.reg_addr)
        A_EN_RISE: rdata_d = en_rise_q;
        A_EN_FALL: rdata_d = en_fall_q;
        A_PENDING: rdata_d = pend_q;
        default:   rdata_d = mask_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_rise_q <= '0;
      en_fall_q <= '0;
      pend_q    <= '0;
      mask_q    <= '0;
      rdata_q   <= '0;
    end else begin
      en_rise_q <= en_rise_d;
      en_fall_q <= en_fall_d;
      pend_q    <= pend_d;
      mask_q    <= mask_d;
      rdata_q   <= rdata_d;
    end
  end

  // Withdrawal looks at next-cycle state so irq drops the cycle after the
  // write that removed the request; an ack in the same cycle takes precedence.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (act_q != '0) begin
            state_q <= REQ;
            vec_q   <= sel;
          end
        end
        REQ: begin
          if (bus.irq_ack)          state_q <= GAP;
          else if (!act_d[vec_q])   state_q <= IDLE;
        end
        GAP:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.irq       = (state_q == REQ);
  assign bus.irq_vec   = vec_q;
  assign bus.reg_rdata = rdata_q;

endmodule
